// File: rtl/coco_timer.sv
// coco_timer: memory-mapped down-counter timer with level interrupt.
// Register map (word select A): 0=CTRL, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// CTRL[0]=En, CTRL[2:1]=Mode (01 auto-reload, anything else one-shot), CTRL[3]=IM.
module coco_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  A,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] DOut,
    output logic        IRQ
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CTRL_W-1:0]  ctrl;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               irq_flag;

    logic               ctrl_en;
    logic               ctrl_im;
    logic               auto_reload;
    logic               count_gt1;

    logic               ctrl_wr;
    logic               preset_wr;

    logic               load_cnt;
    logic               dec_cnt;
    logic               expire;
    logic               clr_en;
    logic               clr_flag;

    assign ctrl_en     = ctrl[0];
    assign ctrl_im     = ctrl[3];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign count_gt1   = (count > CNT_W'(1));

    assign ctrl_wr     = We && (A == ADDR_CTRL);
    assign preset_wr   = We && (A == ADDR_PRESET);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one transition per clock
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl_en) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_nxt = ST_IDLE;
                end else if (!count_gt1) begin
                    state_nxt = ST_INT;
                end
            end
            ST_INT:  state_nxt = auto_reload ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM action strobes driving the datapath registers
    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        expire   = 1'b0;
        clr_en   = 1'b0;
        clr_flag = 1'b0;
        case (state)
            ST_LOAD: load_cnt = 1'b1;
            ST_CNT: begin
                if (ctrl_en) begin
                    if (count_gt1) begin
                        dec_cnt = 1'b1;
                    end else begin
                        expire = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    clr_flag = 1'b1;
                end else begin
                    clr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // CTRL: CPU write takes priority over the one-shot En clear
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl <= '0;
        end else if (ctrl_wr) begin
            ctrl <= Din[CTRL_W-1:0];
        end else if (clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET: only sampled by LOAD, so mid-count writes affect the next period
    always_ff @(posedge Clk) begin
        if (Reset) begin
            preset <= '0;
        end else if (preset_wr) begin
            preset <= Din[CNT_W-1:0];
        end
    end

    // COUNT: load, decrement, or force to zero on expiry; never wraps
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load_cnt) begin
            count <= preset;
        end else if (dec_cnt) begin
            count <= count - CNT_W'(1);
        end else if (expire) begin
            count <= '0;
        end
    end

    // irq_flag: any CTRL write clears it, otherwise set on expiry, cleared on reload
    always_ff @(posedge Clk) begin
        if (Reset) begin
            irq_flag <= 1'b0;
        end else if (ctrl_wr) begin
            irq_flag <= 1'b0;
        end else if (expire) begin
            irq_flag <= 1'b1;
        end else if (clr_flag) begin
            irq_flag <= 1'b0;
        end
    end

    // Read mux, combinational from A and the registers
    always_comb begin
        DOut = '0;
        case (A)
            ADDR_CTRL:   DOut = {27'b0, irq_flag, ctrl};
            ADDR_PRESET: DOut = DATA_W'(preset);
            ADDR_COUNT:  DOut = DATA_W'(count);
            default:     DOut = '0;
        endcase
    end

    // Interrupt request, masked by IM
    assign IRQ = ctrl_im & irq_flag;

endmodule
